// File: rtl/gate_truth_table_sequencer.sv
// Self-test controller that walks an external 3-input gate through all eight
// input vectors, captures its response and grades it against a known table.
module gate_truth_table_sequencer #(
   parameter int         SETTLE_CYCLES = 2,
   parameter logic [7:0] EXPECTED      = 8'h31
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] mismatch_cnt,
   output logic [7:0] truth_table
);

   localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [2:0]       idx;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       final_table;
   logic [7:0]       final_diff;
   logic [3:0]       final_mismatch;
   logic             launch;

   assign launch = start && !abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Abort wins over everything while sweeping; DONE always lasts one cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (launch) state_next = SETTLE;
         end
         SETTLE: begin
            if (abort)                  state_next = IDLE;
            else if (cnt == CNT_LAST)   state_next = SAMPLE;
         end
         SAMPLE: begin
            if (abort)                  state_next = IDLE;
            else if (idx == 3'd7)       state_next = DONE;
            else                        state_next = SETTLE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      {a, b, c} = 3'b000;
      case (state)
         SETTLE, SAMPLE: begin
            busy      = 1'b1;
            {a, b, c} = idx;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // The last vector's y is folded in directly so the verdict lands with DONE.
   always_comb begin
      final_table    = {y, truth_table[6:0]};
      final_diff     = final_table ^ EXPECTED;
      final_mismatch = 4'd0;
      for (int i = 0; i < 8; i++) begin
         final_mismatch = final_mismatch + {3'b000, final_diff[i]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx          <= 3'd0;
         cnt          <= '0;
         truth_table  <= 8'h00;
         pass         <= 1'b0;
         mismatch_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (launch) begin
                  idx          <= 3'd0;
                  cnt          <= '0;
                  truth_table  <= 8'h00;
                  pass         <= 1'b0;
                  mismatch_cnt <= 4'd0;
               end
            end
            SETTLE: begin
               if (abort) begin
                  pass <= 1'b0;
               end else if (cnt != CNT_LAST) begin
                  cnt <= cnt + 1'b1;
               end
            end
            SAMPLE: begin
               if (abort) begin
                  pass <= 1'b0;
               end else begin
                  truth_table[idx] <= y;
                  cnt              <= '0;
                  if (idx == 3'd7) begin
                     pass         <= (final_table == EXPECTED);
                     mismatch_cnt <= final_mismatch;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
